// File: rtl/multi_cycle_adder_if.sv
// Operand/result bundle for multi_cycle_adder.
// Z and its modport entries exist only with MULTI_CYCLE_ADDER_ZERO_FLAG_EN.
interface multi_cycle_adder_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C_IN;
  logic             SUB;
  logic             START;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] Y;
  logic             C_OUT;
  logic             V;
`ifdef MULTI_CYCLE_ADDER_ZERO_FLAG_EN
  logic             Z;

  modport master (
    output A, B, C_IN, SUB, START,
    input  BUSY, DONE, Y, C_OUT, V, Z
  );
  modport slave (
    input  A, B, C_IN, SUB, START,
    output BUSY, DONE, Y, C_OUT, V, Z
  );
`else
  modport master (
    output A, B, C_IN, SUB, START,
    input  BUSY, DONE, Y, C_OUT, V
  );
  modport slave (
    input  A, B, C_IN, SUB, START,
    output BUSY, DONE, Y, C_OUT, V
  );
`endif
endinterface

// File: rtl/multi_cycle_adder.sv
// Chunk-serial WIDTH-bit add/sub: one CHUNK-wide slice, registered carry.
// Optional zero flag Z with MULTI_CYCLE_ADDER_ZERO_FLAG_EN.
module multi_cycle_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic           CLK,
  input logic           N_RST,
  multi_cycle_adder_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] opa_q, opb_q;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] y_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             c_out_q;
  logic             v_q;
  logic [CHUNK:0]   slice;
  logic             msb_cin;
  logic             v_d;
  logic             last;
  logic             accept;

  // Operands shift down so the slice always reads the low chunk;
  // results shift in from the top and land aligned after NCHUNK steps.
  always_comb begin
    slice = {1'b0, opa_q[CHUNK-1:0]}
          + {1'b0, opb_q[CHUNK-1:0]}
          + {{CHUNK{1'b0}}, carry_q};
    work_d = work_q >> CHUNK;
    work_d[WIDTH-1 -: CHUNK] = slice[CHUNK-1:0];
    msb_cin = slice[CHUNK-1]
            ^ opa_q[CHUNK-1]
            ^ opb_q[CHUNK-1];
    v_d  = msb_cin ^ slice[CHUNK];
    last = (cnt_q == LAST);
  end

  always_ff @(posedge CLK) begin
    if (!N_RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (1'b1)
      (state_q == RUN): begin
        if (last) state_d = FIN;
      end
      default: begin
        if (bus.START) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!N_RST) begin
      opa_q   <= '0;
      opb_q   <= '0;
      work_q  <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      v_q     <= 1'b0;
    end else if (accept) begin
      opa_q   <= bus.A;
      opb_q   <= bus.SUB ? ~bus.B : bus.B;
      carry_q <= bus.C_IN;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      opa_q   <= opa_q >> CHUNK;
      opb_q   <= opb_q >> CHUNK;
      carry_q <= slice[CHUNK];
      work_q  <= work_d;
      if (!last) cnt_q <= cnt_q + CW'(1);
      if (last) begin
        y_q     <= work_d;
        c_out_q <= slice[CHUNK];
        v_q     <= v_d;
      end
    end
  end

`ifdef MULTI_CYCLE_ADDER_ZERO_FLAG_EN
  logic zacc_q;
  logic zacc_d;
  logic z_q;

  // Running "all chunks so far were zero" flag.
  assign zacc_d = zacc_q & ~|slice[CHUNK-1:0];

  always_ff @(posedge CLK) begin
    if (!N_RST) begin
      zacc_q <= 1'b0;
      z_q    <= 1'b1;
    end else if (accept) begin
      zacc_q <= 1'b1;
    end else if (state_q == RUN) begin
      zacc_q <= zacc_d;
      if (last) z_q <= zacc_d;
    end
  end

  assign bus.Z = z_q;
`endif

  assign bus.BUSY  = (state_q == RUN);
  assign bus.DONE  = (state_q == FIN);
  assign bus.Y     = y_q;
  assign bus.C_OUT = c_out_q;
  assign bus.V     = v_q;
endmodule

// File: tb/tb_multi_cycle_adder.sv
// Scoreboard bench for multi_cycle_adder (WIDTH=32, CHUNK=8).
// Checks Z too when MULTI_CYCLE_ADDER_ZERO_FLAG_EN is defined.
module tb_multi_cycle_adder;
  localparam int W  = 32;
  localparam int CH = 8;
  localparam int NC = W / CH;

  typedef struct {
    logic [W-1:0] y;
    logic         c;
    logic         v;
    logic         z;
    int           due;
  } exp_t;

  logic clk;
  logic n_rst;
  int   cyc;
  int   vectors;
  int   miscompares;
  logic [W-1:0] last_y;
  exp_t sb[$];

  multi_cycle_adder_if #(.WIDTH(W)) bus ();

  multi_cycle_adder #(
    .WIDTH(W),
    .CHUNK(CH)
  ) dut (
    .CLK  (clk),
    .N_RST(n_rst),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         cin,
    input logic         sub
  );
    exp_t         e;
    logic [W-1:0] bb;
    logic [W:0]   full;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cin};
    e.y  = full[W-1:0];
    e.c  = full[W];
    // two same-sign addends giving a different-sign sum
    e.v  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    e.z  = (full[W-1:0] == '0);
    e.due = 0;
    return e;
  endfunction

  task automatic chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.DONE === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'(bus.DONE), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("y", 64'(bus.Y), 64'(e.y));
          chk("c_out", 64'(bus.C_OUT), 64'(e.c));
          chk("v", 64'(bus.V), 64'(e.v));
`ifdef MULTI_CYCLE_ADDER_ZERO_FLAG_EN
          chk("z", 64'(bus.Z), 64'(e.z));
`endif
          chk("done_cycle", 64'(cyc), 64'(e.due));
          chk("busy_in_fin", 64'(bus.BUSY), 64'd0);
        end
      end
    end
  endtask

  // Call at a negedge; acceptance happens at the following posedge.
  task automatic push_exp(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         cin,
    input logic         sub
  );
    exp_t e;
    e = model(a, b, cin, sub);
    e.due = cyc + 1 + NC;
    sb.push_back(e);
    last_y = e.y;
  endtask

  task automatic issue(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         cin,
    input logic         sub,
    input bit           push
  );
    @(negedge clk);
    bus.A = a;
    bus.B = b;
    bus.C_IN = cin;
    bus.SUB = sub;
    bus.START = 1'b1;
    if (push) push_exp(a, b, cin, sub);
    @(posedge clk);
    #1;
    bus.START = 1'b0;
    bus.A = $urandom;
    bus.B = $urandom;
    bus.C_IN = 1'($urandom);
    bus.SUB = 1'($urandom);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("timeout_pending", 64'(sb.size()), 64'd0);
  endtask

  task automatic run_dir(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         cin,
    input logic         sub
  );
    logic [W-1:0] prev;
    prev = last_y;
    issue(a, b, cin, sub, 1'b1);
    for (int i = 0; i < NC; i++) begin
      @(negedge clk);
      chk("busy_run", 64'(bus.BUSY), 64'd1);
      chk("done_run", 64'(bus.DONE), 64'd0);
      chk("y_stable", 64'(bus.Y), 64'(prev));
    end
    wait_idle();
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    vectors = 0;
    miscompares = 0;
    last_y = '0;
    n_rst = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.C_IN = 1'b0;
    bus.SUB = 1'b0;
    bus.START = 1'b0;
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", 64'(bus.BUSY), 64'd0);
    chk("rst_done", 64'(bus.DONE), 64'd0);
    chk("rst_y", 64'(bus.Y), 64'd0);
    chk("rst_c_out", 64'(bus.C_OUT), 64'd0);
    chk("rst_v", 64'(bus.V), 64'd0);
`ifdef MULTI_CYCLE_ADDER_ZERO_FLAG_EN
    chk("rst_z", 64'(bus.Z), 64'd1);
`endif

    fork
      monitor();
    join_none

    run_dir(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    run_dir(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    run_dir(32'h5, 32'h5, 1'b1, 1'b1);
    run_dir(32'h3, 32'h5, 1'b1, 1'b1);
    run_dir(32'h8000_0000, 32'h1, 1'b1, 1'b1);
    run_dir(32'h1234_5678, 32'h8765_4321, 1'b1, 1'b0);

    // START held high: accepted every NC+1 cycles, operands churn
    for (int c = 0; c < 3 * (NC + 1); c++) begin
      @(negedge clk);
      bus.A = $urandom;
      bus.B = $urandom;
      bus.C_IN = 1'($urandom);
      bus.SUB = 1'($urandom);
      bus.START = 1'b1;
      if (c % (NC + 1) == 0)
        push_exp(bus.A, bus.B, bus.C_IN, bus.SUB);
    end
    @(negedge clk);
    bus.START = 1'b0;
    wait_idle();

    // reset during chunk 2 abandons the op
    run_dir(32'hDEAD_BEEF, 32'h0101_0101, 1'b0, 1'b0);
    issue(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 n_rst = 1'b0;
    @(posedge clk);
    #1 n_rst = 1'b1;
    last_y = '0;
    @(negedge clk);
    chk("mid_rst_busy", 64'(bus.BUSY), 64'd0);
    chk("mid_rst_y", 64'(bus.Y), 64'd0);
    chk("mid_rst_c_out", 64'(bus.C_OUT), 64'd0);
    chk("mid_rst_v", 64'(bus.V), 64'd0);
    repeat (2 * NC) @(negedge clk);
    run_dir(32'h0F0F_0F0F, 32'h00F0_00F1, 1'b0, 1'b0);

    // random ops, some back-to-back via FIN, some with idle gaps
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 4) == 0) ? a : $urandom;
      issue(a, b, 1'($urandom), 1'($urandom), 1'b1);
      repeat (NC + $urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();
    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
